vend_controller: RTL and testbench

Transaction controller for the vending machine. It accumulates credit from coin-acceptor pulses, checks a product selection against its price, and runs a dispense handshake with the product mechanism. It then pays the remaining credit back as 5-unit change pulses. It drives the availability LEDs (0/1/3/7 thermometer code) from the registered credit, so the LED stage follows the transaction instead of a raw coin bus.

---
 rtl/vend_controller.sv | 134 +++++++++++++
 tb/tb_vend_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_controller.sv
`default_nettype none
// ============================================================================
// Module   : vend_controller
// Brief    : Vending transaction controller: credit, selection, dispense
//            handshake and 5-unit change payout.
// Revision : 1.0 - initial release
// ============================================================================
module vend_controller #(
   parameter int P_CANDY    = 15,
   parameter int P_DRINK    = 30,
   parameter int P_SNACK    = 60,
   parameter int MAX_CREDIT = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       coin_5,
   input  logic       coin_10,
   input  logic       coin_50,
   input  logic       sel_candy,
   input  logic       sel_drink,
   input  logic       sel_snack,
   input  logic       cancel,
   input  logic       dispense_ack,
   output logic [5:0] credit,
   output logic [2:0] LEDout,
   output logic       dispense_req,
   output logic [1:0] dispense_item,
   output logic       change_pulse,
   output logic       coin_reject,
   output logic       busy
);

   localparam logic [1:0] c_st_idle     = 2'd0;
   localparam logic [1:0] c_st_credit   = 2'd1;
   localparam logic [1:0] c_st_dispense = 2'd2;
   localparam logic [1:0] c_st_change   = 2'd3;

   localparam logic [5:0] c_p_candy = 6'(P_CANDY);
   localparam logic [5:0] c_p_drink = 6'(P_DRINK);
   localparam logic [5:0] c_p_snack = 6'(P_SNACK);
   localparam logic [6:0] c_max     = 7'(MAX_CREDIT);

   logic [1:0] r_state, w_state_nxt;
   logic [5:0] r_credit, w_credit_nxt;
   logic [1:0] r_item, w_item_nxt;
   logic       r_change, w_change_nxt;
   logic       r_reject, w_reject_nxt;

   logic [1:0] w_coin_cnt, w_sel_cnt;
   logic [5:0] w_coin_val, w_price;
   logic [1:0] w_code;
   logic [6:0] w_sum;
   logic       w_coin_any, w_cmd, w_open, w_coin_ok;

   assign w_coin_cnt = {1'b0, coin_5} + {1'b0, coin_10} + {1'b0, coin_50};
   assign w_sel_cnt  = {1'b0, sel_candy} + {1'b0, sel_drink} + {1'b0, sel_snack};
   assign w_coin_any = coin_5 | coin_10 | coin_50;
   assign w_cmd      = sel_candy | sel_drink | sel_snack | cancel;
   assign w_coin_val = coin_50 ? 6'd50 : (coin_10 ? 6'd10 : (coin_5 ? 6'd5 : 6'd0));
   assign w_price    = sel_snack ? c_p_snack : (sel_drink ? c_p_drink : c_p_candy);
   assign w_code     = sel_snack ? 2'd3 : (sel_drink ? 2'd2 : 2'd1);
   assign w_sum      = {1'b0, r_credit} + {1'b0, w_coin_val};
   assign w_open     = (r_state == c_st_idle) || (r_state == c_st_credit);
   // A coin arriving alongside any select/cancel is refused so the command wins.
   assign w_coin_ok  = w_open && (w_coin_cnt == 2'd1) && !w_cmd && (w_sum <= c_max);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= c_st_idle;
         r_credit <= 6'd0;
         r_item   <= 2'd0;
         r_change <= 1'b0;
         r_reject <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_credit <= w_credit_nxt;
         r_item   <= w_item_nxt;
         r_change <= w_change_nxt;
         r_reject <= w_reject_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_credit_nxt = r_credit;
      w_item_nxt   = r_item;
      w_change_nxt = 1'b0;
      w_reject_nxt = w_coin_any && !w_coin_ok;
      case (r_state)
         c_st_idle, c_st_credit: begin
            if (r_state == c_st_credit && cancel) begin
               w_state_nxt = c_st_change;
            end else if (r_state == c_st_credit && w_sel_cnt == 2'd1 && r_credit >= w_price) begin
               w_credit_nxt = r_credit - w_price;
               w_item_nxt   = w_code;
               w_state_nxt  = c_st_dispense;
            end else if (w_coin_ok) begin
               w_credit_nxt = w_sum[5:0];
               w_state_nxt  = c_st_credit;
            end
         end
         c_st_dispense: begin
            if (dispense_ack) begin
               w_item_nxt  = 2'd0;
               w_state_nxt = (r_credit != 6'd0) ? c_st_change : c_st_idle;
            end
         end
         default: begin
            // Change payout: one 5-unit pulse per cycle until credit empties.
            w_credit_nxt = r_credit - 6'd5;
            w_change_nxt = 1'b1;
            if (r_credit <= 6'd5) begin
               w_credit_nxt = 6'd0;
               w_state_nxt  = c_st_idle;
            end
         end
      endcase
   end

   always_comb begin
      busy          = (r_state == c_st_dispense) || (r_state == c_st_change);
      dispense_req  = (r_state == c_st_dispense);
      dispense_item = r_item;
      change_pulse  = r_change;
      coin_reject   = r_reject;
      credit        = r_credit;
      if (r_credit >= c_p_snack)      LEDout = 3'b111;
      else if (r_credit >= c_p_drink) LEDout = 3'b011;
      else if (r_credit >= c_p_candy) LEDout = 3'b001;
      else                            LEDout = 3'b000;
   end

endmodule
`default_nettype wire

// File: tb/tb_vend_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_controller
// Brief    : Directed self-checking bench for vend_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vend_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       coin_5 = 1'b0, coin_10 = 1'b0, coin_50 = 1'b0;
   logic       sel_candy = 1'b0, sel_drink = 1'b0, sel_snack = 1'b0;
   logic       cancel = 1'b0, dispense_ack = 1'b0;
   logic [5:0] credit;
   logic [2:0] LEDout;
   logic       dispense_req;
   logic [1:0] dispense_item;
   logic       change_pulse, coin_reject, busy;

   int errors = 0;
   int checks = 0;

   vend_controller dut (
      .clk(clk), .rst_n(rst_n),
      .coin_5(coin_5), .coin_10(coin_10), .coin_50(coin_50),
      .sel_candy(sel_candy), .sel_drink(sel_drink), .sel_snack(sel_snack),
      .cancel(cancel), .dispense_ack(dispense_ack),
      .credit(credit), .LEDout(LEDout), .dispense_req(dispense_req),
      .dispense_item(dispense_item), .change_pulse(change_pulse),
      .coin_reject(coin_reject), .busy(busy)
   );

   always #5 clk = ~clk;

   // Advance one edge and settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      coin_5 = 0; coin_10 = 0; coin_50 = 0;
      sel_candy = 0; sel_drink = 0; sel_snack = 0; cancel = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++;
      if ({credit, LEDout, dispense_req, dispense_item, change_pulse, coin_reject, busy} !== 15'd0) begin
         errors++;
         $display("FAIL reset_outputs: got credit=%0d led=%b req=%b item=%0d chg=%b rej=%b busy=%b, need all 0",
                  credit, LEDout, dispense_req, dispense_item, change_pulse, coin_reject, busy);
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_coins();
      coin_10 = 1; tick(); clear_inputs();
      checks++;
      if (credit !== 6'd10 || LEDout !== 3'b000) begin
         errors++;
         $display("FAIL coin10: got credit=%0d led=%b, need 10/000", credit, LEDout);
      end
      coin_5 = 1; tick(); clear_inputs();
      checks++;
      if (credit !== 6'd15 || LEDout !== 3'b001 || busy !== 1'b0 || coin_reject !== 1'b0) begin
         errors++;
         $display("FAIL coin5: got credit=%0d led=%b busy=%b rej=%b, need 15/001/0/0", credit, LEDout, busy, coin_reject);
      end
      coin_10 = 1; tick(); clear_inputs();
      coin_10 = 1; tick(); clear_inputs();
      checks++;
      if (credit !== 6'd35 || LEDout !== 3'b011) begin
         errors++;
         $display("FAIL credit35: got credit=%0d led=%b, need 35/011", credit, LEDout);
      end
   endtask

   task automatic test_dispense_change();
      sel_drink = 1; tick(); clear_inputs();
      checks++;
      if (dispense_req !== 1'b1 || dispense_item !== 2'd2 || credit !== 6'd5 || busy !== 1'b1) begin
         errors++;
         $display("FAIL sel_drink: got req=%b item=%0d credit=%0d busy=%b, need 1/2/5/1",
                  dispense_req, dispense_item, credit, busy);
      end
      coin_5 = 1; tick(); clear_inputs();
      checks++;
      if (coin_reject !== 1'b1 || credit !== 6'd5 || dispense_req !== 1'b1) begin
         errors++;
         $display("FAIL coin_in_dispense: got rej=%b credit=%0d req=%b, need 1/5/1", coin_reject, credit, dispense_req);
      end
      tick();
      dispense_ack = 1; tick(); dispense_ack = 0;
      checks++;
      if (dispense_req !== 1'b0 || dispense_item !== 2'd0 || busy !== 1'b1 || change_pulse !== 1'b0) begin
         errors++;
         $display("FAIL ack_edge: got req=%b item=%0d busy=%b chg=%b, need 0/0/1/0",
                  dispense_req, dispense_item, busy, change_pulse);
      end
      tick();
      checks++;
      if (change_pulse !== 1'b1 || credit !== 6'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL change_one: got chg=%b credit=%0d busy=%b, need 1/0/0", change_pulse, credit, busy);
      end
      tick();
      checks++;
      if (change_pulse !== 1'b0) begin
         errors++;
         $display("FAIL change_end: got chg=%b, need 0", change_pulse);
      end
   endtask

   task automatic test_reject();
      int pulses;
      coin_50 = 1; tick(); clear_inputs();
      coin_50 = 1; tick(); clear_inputs();
      checks++;
      if (coin_reject !== 1'b1 || credit !== 6'd50) begin
         errors++;
         $display("FAIL overflow_reject: got rej=%b credit=%0d, need 1/50", coin_reject, credit);
      end
      tick();
      checks++;
      if (coin_reject !== 1'b0) begin
         errors++;
         $display("FAIL reject_width: got rej=%b, need 0", coin_reject);
      end
      coin_5 = 1; coin_10 = 1; tick(); clear_inputs();
      checks++;
      if (coin_reject !== 1'b1 || credit !== 6'd50) begin
         errors++;
         $display("FAIL double_coin: got rej=%b credit=%0d, need 1/50", coin_reject, credit);
      end
      cancel = 1; tick(); clear_inputs();
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (change_pulse) pulses++;
      end
      checks++;
      if (pulses !== 10 || credit !== 6'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL refund50: got pulses=%0d credit=%0d busy=%b, need 10/0/0", pulses, credit, busy);
      end
   endtask

   task automatic test_cancel_wins();
      int pulses;
      coin_10 = 1; tick(); clear_inputs();
      coin_10 = 1; tick(); clear_inputs();
      sel_snack = 1; tick(); clear_inputs();
      checks++;
      if (credit !== 6'd20 || dispense_req !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL snack_short: got credit=%0d req=%b busy=%b, need 20/0/0", credit, dispense_req, busy);
      end
      sel_candy = 1; cancel = 1; tick(); clear_inputs();
      checks++;
      if (dispense_req !== 1'b0 || busy !== 1'b1 || credit !== 6'd20) begin
         errors++;
         $display("FAIL cancel_wins: got req=%b busy=%b credit=%0d, need 0/1/20", dispense_req, busy, credit);
      end
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (change_pulse) pulses++;
      end
      checks++;
      if (pulses !== 4 || credit !== 6'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL refund20: got pulses=%0d credit=%0d busy=%b, need 4/0/0", pulses, credit, busy);
      end
   endtask

   task automatic test_ack_held();
      int pulses;
      coin_50 = 1; tick(); clear_inputs();
      coin_10 = 1; tick(); clear_inputs();
      checks++;
      if (credit !== 6'd60 || LEDout !== 3'b111) begin
         errors++;
         $display("FAIL credit60: got credit=%0d led=%b, need 60/111", credit, LEDout);
      end
      dispense_ack = 1;
      sel_snack = 1; tick(); clear_inputs();
      checks++;
      if (dispense_req !== 1'b1 || dispense_item !== 2'd3 || credit !== 6'd0) begin
         errors++;
         $display("FAIL sel_snack: got req=%b item=%0d credit=%0d, need 1/3/0", dispense_req, dispense_item, credit);
      end
      tick();
      checks++;
      if (dispense_req !== 1'b0 || dispense_item !== 2'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL ack_held: got req=%b item=%0d busy=%b, need 0/0/0", dispense_req, dispense_item, busy);
      end
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (change_pulse) pulses++;
      end
      dispense_ack = 0;
      checks++;
      if (pulses !== 0) begin
         errors++;
         $display("FAIL no_change: got pulses=%0d, need 0", pulses);
      end
   endtask

   task automatic test_reset_mid_change();
      int pulses;
      coin_10 = 1; tick(); clear_inputs();
      coin_10 = 1; tick(); clear_inputs();
      coin_5  = 1; tick(); clear_inputs();
      cancel  = 1; tick(); clear_inputs();
      tick();
      tick();
      checks++;
      if (credit !== 6'd15 || change_pulse !== 1'b1) begin
         errors++;
         $display("FAIL mid_change: got credit=%0d chg=%b, need 15/1", credit, change_pulse);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({credit, LEDout, dispense_req, dispense_item, change_pulse, coin_reject, busy} !== 15'd0) begin
         errors++;
         $display("FAIL async_reset: got credit=%0d led=%b req=%b item=%0d chg=%b rej=%b busy=%b, need all 0",
                  credit, LEDout, dispense_req, dispense_item, change_pulse, coin_reject, busy);
      end
      tick();
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (change_pulse) pulses++;
      end
      checks++;
      if (pulses !== 0 || credit !== 6'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL after_reset: got pulses=%0d credit=%0d busy=%b, need 0/0/0", pulses, credit, busy);
      end
   endtask

   initial begin
      test_reset();
      test_coins();
      test_dispense_change();
      test_reject();
      test_cancel_wins();
      test_ack_held();
      test_reset_mid_change();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
